ps2_key_controller: RTL and testbench

PS2_KEY_CONTROLLER -- requirements
Module: ps2_key_controller

---
 rtl/ps2_key_controller.sv | 257 +++++++++++++++++++++++++
 tb/tb_ps2_key_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_controller.sv
// ps2_key_controller
//   Receives PS/2 keyboard frames (start, 8 data bits LSB-first, parity, stop),
//   folds the E0 (extended) and F0 (break) prefixes into flags, and queues one
//   {ext, brk, code} key event per completed key code in a small FIFO.
//
// Build option:
//   PS2_PARITY_CHECK_EN - when defined, frames must carry odd parity over the
//                         8 data bits plus the parity bit; when undefined the
//                         parity bit is received but ignored.
//
// Parameters:
//   TIMEOUT_CYCLES - clk cycles without a PS/2 falling edge that abort a frame
//   FIFO_DEPTH     - key-event entries held (power of 2, 2..16)
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   synchronous active-high reset
//   PS2KeyboardClk  in   PS/2 clock pin (asynchronous)
//   PS2KeyboardData in   PS/2 data pin (asynchronous)
//   key_valid       out  FIFO head entry valid
//   key_ready       in   consumer accepts head entry
//   key_code        out  head entry scan code
//   key_break       out  head entry is a release
//   key_ext         out  head entry is extended
//   frame_err       out  one-cycle pulse per rejected / timed-out frame
//   fifo_overflow   out  sticky, an event was dropped on a full FIFO
module ps2_key_controller #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2KeyboardClk,
    input  logic       PS2KeyboardData,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_err,
    output logic       fifo_overflow
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST_C = GW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [7:0]    CODE_EXT_C = 8'hE0;
    localparam logic [7:0]    CODE_BRK_C = 8'hF0;

`ifdef PS2_PARITY_CHECK_EN
    localparam logic PARITY_EN_C = 1'b1;
`else
    localparam logic PARITY_EN_C = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // synchronizer / edge detect
    logic ps2c_meta_r, ps2c_sync_r, ps2c_prev_r;
    logic ps2d_meta_r, ps2d_sync_r, ps2d_dly_r;
    logic fall_r;

    // frame receiver
    state_t          state_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            parity_r;
    logic [GW-1:0]   gap_cnt_r;
    logic            ext_r;
    logic            brk_r;
    logic            frame_err_r;
    logic            push_r;
    logic [9:0]      push_data_r;
    logic            parity_ok_s;

    // event FIFO
    logic [9:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            overflow_r;
    logic            pop_s;
    logic            full_s;
    logic            wr_en_s;
    logic [9:0]      head_s;

    assign parity_ok_s = ~PARITY_EN_C | odd_parity_ok(shift_r, parity_r);

    // Two-flop synchronizers; data is delayed one extra stage so it lines up with fall_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_meta_r <= 1'b1;
            ps2c_sync_r <= 1'b1;
            ps2c_prev_r <= 1'b1;
            ps2d_meta_r <= 1'b1;
            ps2d_sync_r <= 1'b1;
            ps2d_dly_r  <= 1'b1;
            fall_r      <= 1'b0;
        end else begin
            ps2c_meta_r <= PS2KeyboardClk;
            ps2c_sync_r <= ps2c_meta_r;
            ps2c_prev_r <= ps2c_sync_r;
            ps2d_meta_r <= PS2KeyboardData;
            ps2d_sync_r <= ps2d_meta_r;
            ps2d_dly_r  <= ps2d_sync_r;
            fall_r      <= ps2c_prev_r & ~ps2c_sync_r;
        end
    end

    // Frame FSM: bit collection, prefix flags, gap timeout and push request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            parity_r    <= 1'b0;
            gap_cnt_r   <= '0;
            ext_r       <= 1'b0;
            brk_r       <= 1'b0;
            frame_err_r <= 1'b0;
            push_r      <= 1'b0;
            push_data_r <= 10'h000;
        end else begin
            frame_err_r <= 1'b0;
            push_r      <= 1'b0;
            if (fall_r) begin
                gap_cnt_r <= '0;
                case (state_r)
                    ST_IDLE: begin
                        // A high data line at a fall is not a start bit; ignore it silently.
                        if (!ps2d_dly_r) begin
                            state_r   <= ST_DATA;
                            bit_idx_r <= 3'd0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        shift_r <= {ps2d_dly_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_PARITY;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        parity_r <= ps2d_dly_r;
                        state_r  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_r <= ST_IDLE;
                        if (ps2d_dly_r && parity_ok_s) begin
                            if (shift_r == CODE_EXT_C) begin
                                ext_r <= 1'b1;
                            end else if (shift_r == CODE_BRK_C) begin
                                brk_r <= 1'b1;
                            end else begin
                                push_r      <= 1'b1;
                                push_data_r <= {ext_r, brk_r, shift_r};
                                ext_r       <= 1'b0;
                                brk_r       <= 1'b0;
                            end
                        end else begin
                            frame_err_r <= 1'b1;
                            ext_r       <= 1'b0;
                            brk_r       <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end else if (state_r != ST_IDLE) begin
                // The keyboard went quiet mid-frame: abandon the partial byte.
                if (gap_cnt_r == GAP_LAST_C) begin
                    state_r     <= ST_IDLE;
                    gap_cnt_r   <= '0;
                    bit_idx_r   <= 3'd0;
                    shift_r     <= 8'h00;
                    frame_err_r <= 1'b1;
                    ext_r       <= 1'b0;
                    brk_r       <= 1'b0;
                end else begin
                    gap_cnt_r <= gap_cnt_r + GW'(1);
                end
            end else begin
                gap_cnt_r <= '0;
            end
        end
    end

    assign pop_s   = (count_r != '0) & key_ready;
    assign full_s  = (count_r == DEPTH_C);
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign wr_en_s = push_r & (~full_s | pop_s);

    // FIFO storage; contents need no reset because outputs are gated by key_valid.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data_r;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (push_r && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign head_s        = mem_r[rd_ptr_r];
    assign key_valid     = (count_r != '0);
    assign key_code      = key_valid ? head_s[7:0] : 8'h00;
    assign key_break     = key_valid & head_s[8];
    assign key_ext       = key_valid & head_s[9];
    assign frame_err     = frame_err_r;
    assign fifo_overflow = overflow_r;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Self-checking bench for ps2_key_controller: bit-level PS/2 frame driver,
// a key-event reference model (prefix flags + bounded queue) and per-scenario tasks.
module tb_ps2_key_controller;

    localparam int TO    = 300;
    localparam int DEPTH = 4;
    localparam int HALF  = 15;

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic       frame_err;
    logic       fifo_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int exp_err  = 0;

    logic [9:0] model_q[$];
    bit m_ext = 1'b0;
    bit m_brk = 1'b0;
    bit m_ovf = 1'b0;

    ps2_key_controller #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .PS2KeyboardClk(ps2_clk),
        .PS2KeyboardData(ps2_data),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_code(key_code),
        .key_break(key_break),
        .key_ext(key_ext),
        .frame_err(frame_err),
        .fifo_overflow(fifo_overflow)
    );

    always #5 clk = ~clk;

    // frame_err is a single-cycle pulse, so each negedge sighting is one event
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        model_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        bit good;
        good = !bad_stop && !(PAR_EN && bad_par);
        if (!good) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (model_q.size() < DEPTH) model_q.push_back({m_ext, m_brk, b});
            else m_ovf = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        model_frame(b, bad_par, bad_stop);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        logic [9:0] exp;
        logic [9:0] got;
        int guard = 0;
        @(negedge clk);
        while (key_valid === 1'b1 && guard < 2 * DEPTH) begin
            got = {key_ext, key_break, key_code};
            n_checks++;
            if (model_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s_extra: got entry %h, required none", name, got);
            end else begin
                exp = model_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL %s_entry: got {ext,brk,code}=%h, required %h", name, got, exp);
                end
            end
            key_ready = 1'b1;
            @(negedge clk);
            key_ready = 1'b0;
            guard++;
        end
        n_checks++;
        if (model_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing: %0d entries not delivered, required 0", name, model_q.size());
            model_q.delete();
        end
    endtask

    task automatic check_err(input string name);
        n_checks++;
        if (err_cnt !== exp_err) begin
            n_fail++;
            $display("FAIL %s_frame_err: got %0d pulses, required %0d", name, err_cnt, exp_err);
            exp_err = err_cnt;
        end
    endtask

    task automatic check_ovf(input string name);
        n_checks++;
        if (fifo_overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL %s_overflow: got %b, required %b", name, fifo_overflow, m_ovf);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({key_valid, key_code, key_break, key_ext, frame_err, fifo_overflow} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {key_valid, key_code, key_break, key_ext, frame_err, fifo_overflow});
        end
        reset = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        n_checks++;
        if (key_valid !== 1'b0 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_idle: got valid=%b errs=%0d, required 0/0", key_valid, err_cnt);
        end
    endtask

    task automatic test_make_code();
        send_frame(8'h1C, 1'b0, 1'b0);
        drain("make");
        check_err("make");
    endtask

    task automatic test_break();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        drain("break");
    endtask

    task automatic test_ext_break();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        drain("ext_break");
        check_err("ext_break");
    endtask

    task automatic test_parity();
        send_frame(8'h1C, 1'b1, 1'b0);
        check_err("parity");
        drain("parity");
    endtask

    task automatic test_bad_stop();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1);
        check_err("bad_stop");
        send_frame(8'h1C, 1'b0, 1'b0);
        drain("bad_stop");
    endtask

    task automatic test_timeout();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        repeat (TO + 20) @(negedge clk);
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        check_err("timeout");
        send_frame(8'h1C, 1'b0, 1'b0);
        drain("timeout");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0);
        check_ovf("overflow");
        drain("overflow");
        check_ovf("overflow_sticky");
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        do_reset();
        n_checks++;
        if (key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_valid: got %b, required 0", key_valid);
        end
        repeat (TO + 20) @(negedge clk);
        check_err("midreset");
        send_frame(8'h1C, 1'b0, 1'b0);
        drain("midreset");
    endtask

    task automatic test_random();
        logic [7:0] b;
        int sel;
        do_reset();
        for (int n = 0; n < 36; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 8'hE0;
            else if (sel == 1) b = 8'hF0;
            else b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 3) == 0) drain("random");
        end
        drain("random_final");
        check_err("random");
        check_ovf("random");
    endtask

    initial begin
        test_reset();
        test_make_code();
        test_break();
        test_ext_break();
        test_parity();
        test_bad_stop();
        test_timeout();
        test_overflow();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
